// File: rtl/game_ctrl.sv
// Snake game controller: run/pause/over FSM, step tick generator and a short
// pending-turn queue that feeds one direction change per step.
package snake_pkg;
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            default: return NONE;
        endcase
    endfunction
endpackage

module game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6_500_000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  dir_t        key_dir,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        collide,
    output logic        step,
    output dir_t        dir_out,
    output logic        map_rst,
    output logic [1:0]  state,
    output logic [15:0] step_cnt
);
    localparam int unsigned   TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int unsigned   QW        = 3;
    localparam logic [QW-1:0] QFULL     = QW'(QDEPTH);

    game_state_t   state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    dir_t          dir_q, dir_d;
    logic [15:0]   cnt_q, cnt_d;
    dir_t          q_q [QDEPTH];
    dir_t          q_d [QDEPTH];
    logic [QW-1:0] qn_q, qn_d;
    logic          after_step_q, after_step_d;
    logic          fire;
    logic          accept;
    dir_t          ref_dir;

    always_comb begin
        // NOTE: every signal written in this block gets a default first, so no latch is inferred.
        state_d      = state_q;
        tick_d       = tick_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        q_d          = q_q;
        qn_d         = qn_q;
        after_step_d = 1'b0;
        map_rst      = 1'b0;

        fire = (state_q == RUN) && (tick_q == TICK_LAST);

        // Pop before push: a turn leaving the queue this step becomes the new reference.
        if (fire && (qn_q != '0)) begin
            for (int i = 0; i < int'(QDEPTH) - 1; i++) q_d[i] = q_q[i+1];
            q_d[QDEPTH-1] = NONE;
            qn_d          = qn_q - QW'(1);
            dir_d         = q_q[0];
        end

        ref_dir = dir_d;
        for (int i = 0; i < int'(QDEPTH); i++)
            if (qn_d == QW'(i + 1)) ref_dir = q_d[i];

        accept = key_valid && (state_q == RUN || state_q == PAUSE) && (key_dir != NONE)
              && (key_dir != ref_dir) && (key_dir != opposite(ref_dir)) && (qn_d != QFULL);
        if (accept) begin
            for (int i = 0; i < int'(QDEPTH); i++)
                if (qn_d == QW'(i)) q_d[i] = key_dir;
            qn_d = qn_d + QW'(1);
        end

        step    = fire;
        dir_out = dir_d;

        case (state_q)
            IDLE, OVER: begin
                tick_d = '0;
                if (btn_start) begin
                    state_d = RUN;
                    map_rst = 1'b1;
                    dir_d   = UP;
                    cnt_d   = '0;
                    qn_d    = '0;
                    for (int i = 0; i < int'(QDEPTH); i++) q_d[i] = NONE;
                end
            end
            RUN: begin
                tick_d       = fire ? '0 : tick_q + TW'(1);
                after_step_d = fire;
                if (fire && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
                // A collision report outranks both strobes in the same cycle.
                if (after_step_q && collide) state_d = OVER;
                else if (btn_pause)          state_d = PAUSE;
            end
            PAUSE: begin
                if (btn_pause) state_d = RUN;
            end
            default: ;
        endcase

        if (rst) begin
            step    = 1'b0;
            map_rst = 1'b0;
            dir_out = NONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            dir_q        <= NONE;
            cnt_q        <= '0;
            qn_q         <= '0;
            after_step_q <= 1'b0;
            // NOTE: the queue entries are cleared too; they are only a few flops, and it keeps them free of X.
            for (int i = 0; i < int'(QDEPTH); i++) q_q[i] <= NONE;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            qn_q         <= qn_d;
            after_step_q <= after_step_d;
            q_q          <= q_d;
        end
    end

    assign state    = state_q;
    assign step_cnt = cnt_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random stimulus,
// all compared against a queue-based behavioural model of the game rules.
module tb_game_ctrl;
    import snake_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int QDEPTH   = 2;

    logic        clk, rst, key_valid, btn_start, btn_pause, collide;
    dir_t        key_dir;
    logic        step, map_rst;
    dir_t        dir_out;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    game_ctrl #(.TICK_DIV(TICK_DIV), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_dir(key_dir),
        .btn_start(btn_start), .btn_pause(btn_pause), .collide(collide),
        .step(step), .dir_out(dir_out), .map_rst(map_rst),
        .state(state), .step_cnt(step_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 over; phase = cycles since the last step/start.
    int          m_mode  = 0;
    int          m_phase = 0;
    dir_t        m_dir   = NONE;
    dir_t        m_q[$];
    int          m_steps = 0;
    bit          m_after = 0;
    bit          m_fire  = 0;
    logic [22:0] exp_vec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no summary, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    function automatic dir_t m_opp(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [22:0] dut_vec();
        return {state, map_rst, step, dir_out, step_cnt};
    endfunction

    // Drive one cycle's inputs and compute the outputs the rules predict for it.
    task automatic apply(input logic r, input logic kv, input dir_t kd,
                         input logic bs, input logic bp, input logic col);
        dir_t ed;
        logic emr;
        rst = r; key_valid = kv; key_dir = kd; btn_start = bs; btn_pause = bp; collide = col;
        m_fire = !r && (m_mode == 1) && (m_phase == TICK_DIV - 1);
        ed  = (m_fire && m_q.size() > 0) ? m_q[0] : m_dir;
        emr = (m_mode == 0 || m_mode == 3) && bs;
        if (r) exp_vec = {2'(m_mode), 1'b0, 1'b0, NONE, 16'(m_steps)};
        else   exp_vec = {2'(m_mode), emr, m_fire, ed, 16'(m_steps)};
        #2;
    endtask

    // Clock edge: advance the model by the game rules.
    task automatic advance();
        dir_t rd;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_phase = 0; m_dir = NONE; m_steps = 0; m_after = 0;
            m_q.delete();
        end else begin
            if (m_fire) begin
                if (m_q.size() > 0) m_dir = m_q.pop_front();
                if (m_steps < 65535) m_steps++;
            end
            if ((m_mode == 1 || m_mode == 2) && key_valid && key_dir != NONE && m_q.size() < QDEPTH) begin
                rd = (m_q.size() > 0) ? m_q[$] : m_dir;
                if (key_dir != rd && key_dir != m_opp(rd)) m_q.push_back(key_dir);
            end
            case (m_mode)
                1: begin
                    m_phase = m_fire ? 0 : m_phase + 1;
                    if (m_after && collide) m_mode = 3;
                    else if (btn_pause)     m_mode = 2;
                    m_after = m_fire;
                end
                2: begin
                    m_after = 0;
                    if (btn_pause) m_mode = 1;
                end
                default: begin
                    m_phase = 0;
                    m_after = 0;
                    if (btn_start) begin
                        m_mode = 1; m_dir = UP; m_steps = 0;
                        m_q.delete();
                    end
                end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'($urandom), UP, 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL reset_cycle%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            advance();
        end
        apply(1'b0, 1'b0, NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== {2'b00, 1'b0, 1'b0, NONE, 16'd0}) begin
            errors++; $display("FAIL reset_state: got %h required %h", dut_vec(), {2'b00, 1'b0, 1'b0, NONE, 16'd0});
        end
        advance();
    endtask

    task automatic test_start_steps();
        logic [12:0] seen = '0;
        logic        mr0  = 1'b0;
        for (int c = 0; c < 13; c++) begin
            apply(1'b0, 1'b0, NONE, c == 0, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL start_cycle%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            seen[c] = step;
            if (c == 0) mr0 = map_rst;
            advance();
        end
        checks++;
        if (mr0 !== 1'b1) begin
            errors++; $display("FAIL start_map_rst: got %b required 1", mr0);
        end
        checks++;
        if (seen !== 13'b1_0001_0001_0000) begin
            errors++; $display("FAIL start_step_cycles: got %b required 1000100010000", seen);
        end
        checks++;
        if ({dir_out, step_cnt} !== {UP, 16'd3}) begin
            errors++; $display("FAIL start_dir_cnt: got %0d/%0d required %0d/3", dir_out, step_cnt, UP);
        end
    endtask

    // Keys are offered in the first four cycles from a phase-0 start; dirs seen at steps are checked.
    task automatic run_turns(input string name, input dir_t k0, input dir_t k1, input dir_t k2,
                             input dir_t k3, input int nexp, input dir_t e0, input dir_t e1, input dir_t e2);
        dir_t keys[4];
        dir_t expd[3];
        dir_t got[3];
        dir_t kd;
        int   n = 0;
        keys = '{k0, k1, k2, k3};
        expd = '{e0, e1, e2};
        got  = '{NONE, NONE, NONE};
        for (int c = 0; c < 24 && n < nexp; c++) begin
            kd = NONE;
            if (c < 4) kd = keys[c];
            apply(1'b0, kd != NONE, kd, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL %s_cycle%0d: got %h required %h", name, c, dut_vec(), exp_vec);
            end
            if (step === 1'b1) begin got[n] = dir_out; n++; end
            advance();
        end
        for (int i = 0; i < nexp; i++) begin
            checks++;
            if (n <= i || got[i] !== expd[i]) begin
                errors++; $display("FAIL %s_step%0d_dir: got %0d required %0d", name, i, got[i], expd[i]);
            end
        end
    endtask

    task automatic test_turn_queue();
        run_turns("turn_queue", LEFT, UP, NONE, NONE, 2, LEFT, UP, NONE);
    endtask

    task automatic test_drop_reverse();
        run_turns("drop_reverse", DOWN, UP, NONE, NONE, 1, UP, NONE, NONE);
    endtask

    task automatic test_full_queue();
        run_turns("full_queue", LEFT, DOWN, RIGHT, RIGHT, 3, LEFT, DOWN, RIGHT);
    endtask

    task automatic test_pause();
        int nsteps = 0;
        int lat    = 0;
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 1'b0, NONE, 1'b0, c == 1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL pause_enter%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            advance();
        end
        // The counter is now frozen at 2.
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 1'b0, NONE, 1'($urandom), 1'b0, 1'($urandom));
            checks++;
            if (dut_vec() !== exp_vec || state !== 2'b10) begin
                errors++; $display("FAIL pause_hold%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            if (step === 1'b1) nsteps++;
            advance();
        end
        checks++;
        if (nsteps != 0) begin
            errors++; $display("FAIL pause_no_step: got %0d steps required 0", nsteps);
        end
        for (int k = 0; k < 8 && lat == 0; k++) begin
            apply(1'b0, 1'b0, NONE, 1'b0, k == 0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL pause_resume%0d: got %h required %h", k, dut_vec(), exp_vec);
            end
            if (step === 1'b1) lat = k;
            advance();
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL pause_resume_latency: got %0d required 2", lat);
        end
    endtask

    task automatic test_collide();
        logic fired  = 1'b0;
        int   nsteps = 0;
        for (int c = 0; c < 8 && !fired; c++) begin
            apply(1'b0, 1'b0, NONE, 1'b0, 1'b0, c == 1);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL collide_run%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            fired = step;
            advance();
        end
        checks++;
        if (fired !== 1'b1) begin
            errors++; $display("FAIL collide_step_budget: got no step required one within 8 cycles");
        end
        apply(1'b0, 1'b0, NONE, 1'b1, 1'b0, 1'b1);
        advance();
        checks++;
        if (state !== 2'b11) begin
            errors++; $display("FAIL collide_over: got %b required 11", state);
        end
        for (int c = 0; c < 8; c++) begin
            apply(1'b0, 1'($urandom), dir_t'(3'($urandom_range(0, 4))), 1'b0, 1'($urandom), 1'($urandom));
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL over_hold%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            if (step === 1'b1) nsteps++;
            advance();
        end
        checks++;
        if (nsteps != 0) begin
            errors++; $display("FAIL over_no_step: got %0d steps required 0", nsteps);
        end
        apply(1'b0, 1'b0, NONE, 1'b1, 1'b0, 1'b0);
        checks++;
        if (map_rst !== 1'b1) begin
            errors++; $display("FAIL restart_map_rst: got %b required 1", map_rst);
        end
        advance();
        checks++;
        if ({state, dir_out, step_cnt} !== {2'b01, UP, 16'd0}) begin
            errors++; $display("FAIL restart_state: got %b/%0d/%0d required 01/%0d/0", state, dir_out, step_cnt, UP);
        end
    endtask

    task automatic test_reset_midrun();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, NONE, 1'b0, 1'b0, 1'b0);
            advance();
        end
        // Counter is at its last value here, so a step would fire without the reset.
        apply(1'b1, 1'b0, NONE, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({map_rst, step} !== 2'b00 || dut_vec() !== exp_vec) begin
            errors++; $display("FAIL midrun_reset_cycle: got %h required %h", dut_vec(), exp_vec);
        end
        advance();
        apply(1'b0, 1'b0, NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({map_rst, step} !== 2'b00 || state !== 2'b00) begin
            errors++; $display("FAIL midrun_after_reset: got %h required state 00 with no pulses", dut_vec());
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  dir_t'(3'($urandom_range(0, 4))), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++; $display("FAIL random_cycle%0d: got %h required %h", c, dut_vec(), exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_dir = NONE;
        btn_start = 1'b0; btn_pause = 1'b0; collide = 1'b0;
        apply(1'b1, 1'b0, NONE, 1'b0, 1'b0, 1'b0);
        advance();
        test_reset();
        test_start_steps();
        test_turn_queue();
        test_drop_reverse();
        test_full_queue();
        test_pause();
        test_collide();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
